// File: rtl/kbd_pkg.sv
// Shared constants, FSM encoding and character mapping for the typematic FIFO.
package kbd_pkg;

  localparam int DEFAULT_DEPTH         = 16;
  localparam int DEFAULT_DELAY_CYCLES  = 25000000;
  localparam int DEFAULT_REPEAT_CYCLES = 5000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Counter width able to hold max(a, b) - 1; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Ctrl folds 0x40..0x7F onto control codes 0x00..0x1F.
  function automatic logic [7:0] map_char(input logic [7:0] ascii, input logic ctrl);
    return (ctrl && ascii[7:6] == 2'b01) ? (ascii & 8'h1F) : ascii;
  endfunction

endpackage

// File: rtl/kbd_typematic_fifo_if.sv
// Key-side inputs and consumer-side FIFO signals of the typematic FIFO.
interface kbd_typematic_fifo_if #(
  parameter int DEPTH = 16
);
  logic [7:0]             cur_key;
  logic [7:0]             ascii_key;
  logic                   ctrl;
  logic                   rd_en;
  logic                   clr_ovf;
  logic [7:0]             rd_data;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  modport master (
    output cur_key, ascii_key, ctrl, rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  cur_key, ascii_key, ctrl, rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/kbd_fifo.sv
// Synchronous first-word-fall-through byte FIFO with sticky overflow flag.
module kbd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  input  logic                   clr_ovf,
  output logic [7:0]             rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop, ovf_evt;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // Pop on empty is ignored; a full FIFO still accepts when a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_evt = push && full && !do_pop;
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)        overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: rtl/kbd_typematic_fifo.sv
// Keyboard typematic engine: press detect, delay/repeat timing, char mapping, FIFO.
module kbd_typematic_fifo
  import kbd_pkg::*;
#(
  parameter int DELAY_CYCLES  = DEFAULT_DELAY_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
  parameter int DEPTH         = DEFAULT_DEPTH
) (
  input logic                 clk,
  input logic                 clrn,
  kbd_typematic_fifo_if.slave bus
);
  localparam int CW = cnt_width(DELAY_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

  logic [7:0]    key_r, prev_key, ascii_r;
  logic          ctrl_r;
  logic          press, fire, push;
  logic [7:0]    chr;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Sample decoder outputs once; prev_key remembers the prior sample for edge detect.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_r    <= 8'h00;
      prev_key <= 8'h00;
      ascii_r  <= 8'h00;
      ctrl_r   <= 1'b0;
    end else begin
      key_r    <= bus.cur_key;
      prev_key <= key_r;
      ascii_r  <= bus.ascii_key;
      ctrl_r   <= bus.ctrl;
    end
  end

  assign press = (key_r != 8'h00) && (key_r != prev_key);
  assign chr   = map_char(ascii_r, ctrl_r);
  // Timing still runs for non-printable keys; only the push is suppressed.
  assign push  = fire && (chr != 8'h00);

  // State and timer registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: release beats new press beats timer expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press) begin
          fire      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (key_r == 8'h00) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (press) begin
          fire      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_DELAY;
        end else if (state == ST_DELAY && cnt == DLY_LAST) begin
          fire      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_REPEAT;
        end else if (state == ST_REPEAT && cnt == RPT_LAST) begin
          fire      = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .clrn     (clrn),
    .push     (push),
    .wdata    (chr),
    .pop      (bus.rd_en),
    .clr_ovf  (bus.clr_ovf),
    .rdata    (bus.rd_data),
    .empty    (bus.empty),
    .full     (bus.full),
    .count    (bus.count),
    .overflow (bus.overflow)
  );

endmodule

// File: doc/kbd_typematic_fifo.md
KBD_TYPEMATIC_FIFO -- requirements
Module: kbd_typematic_fifo

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 25000000, meaning clk cycles from first press to first auto-repeat.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 5000000, meaning clk cycles between auto-repeats.
REQ-003 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two).
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 cur_key  input  8  held scan code from keyboard decoder; 8'h00 means no key held.
REQ-007 ascii_key  input  8  ASCII of cur_key, case already resolved; 8'h00 means non-printable.
REQ-008 ctrl  input  1  Ctrl modifier held.
REQ-009 rd_en  input  1  consumer pop strobe, one entry per asserted cycle.
REQ-010 clr_ovf  input  1  clears overflow.
REQ-011 rd_data  output  8  FIFO head, first-word fall-through; 8'h00 when empty.
REQ-012 empty  output  1  FIFO holds zero entries.
REQ-013 full  output  1  FIFO holds DEPTH entries.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky; a character was dropped.

Function
REQ-016 Inputs cur_key, ascii_key and ctrl SHALL be registered once (prev_key holds the prior sample); all decisions use the registered values.
REQ-017 Press event SHALL be: registered cur_key != 0 and != prev_key.
REQ-018 Character SHALL be ascii_key & 8'h1F when ctrl=1 and ascii_key is in 8'h40..8'h7F, else ascii_key; character 8'h00 SHALL never be pushed.
REQ-019 FSM states SHALL be IDLE, DELAY, REPEAT, with a counter sized for max(DELAY_CYCLES, REPEAT_CYCLES).
REQ-020 IDLE: on press event push character, clear counter, go DELAY.
REQ-021 DELAY/REPEAT: cur_key == 0 SHALL go IDLE with no push.
REQ-022 DELAY/REPEAT: press event of a different key SHALL push its character, clear counter, go DELAY.
REQ-023 DELAY: counter == DELAY_CYCLES-1 SHALL push, clear counter, go REPEAT.
REQ-024 REPEAT: counter == REPEAT_CYCLES-1 SHALL push and clear counter; otherwise counter increments.
REQ-025 Push SHALL become visible on rd_data/empty/count the cycle after the push decision (latency 1 from registered press).
REQ-026 rd_en while empty SHALL be ignored with no pointer or count change.
REQ-027 Push while full without same-cycle pop SHALL drop the character and set overflow.
REQ-028 Push and pop in the same cycle SHALL both succeed, count unchanged, including when full.
REQ-029 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-030 clr_ovf SHALL clear overflow next cycle; a same-cycle overflow event SHALL win (overflow stays 1).

Reset
REQ-031 clrn=0 SHALL immediately force state IDLE, counter 0, prev_key 0, pointers 0, count 0, empty 1, full 0, overflow 0, rd_data 8'h00.
REQ-032 Reset mid-DELAY/REPEAT SHALL discard pending repeat; after release a still-held key SHALL count as a new press event.

Structure
REQ-033 Shared package kbd_pkg SHALL hold the FSM state encoding, DEFAULT_DEPTH, and default DELAY/REPEAT constants.
REQ-034 FIFO storage/pointers SHALL be one sub-module kbd_fifo (synchronous FWFT, push/pop/full/empty/count); FSM and character mapping stay in the top.

Verification (DELAY_CYCLES=8, REPEAT_CYCLES=4, DEPTH=4)
REQ-035 cur_key 8'h1C, ascii 8'h61 held 3 cycles then 0 -> exactly one 8'h61 in FIFO, count=1, back to IDLE.
REQ-036 Hold cur_key 8'h1C, ascii 8'h61 for 20 cycles -> pushes at press, +8, +12, +16, +20 cycles relative to registered press; overflow=1 after 5th push, count=4.
REQ-037 ctrl=1, ascii 8'h63 press -> 8'h03 pushed; ascii 8'h00 press -> nothing pushed, state still goes DELAY.
REQ-038 FIFO full (4 entries), push with rd_en=1 same cycle -> count stays 4, overflow stays 0, head advances.
REQ-039 rd_en on empty -> count 0, rd_data 8'h00; clr_ovf with simultaneous overflow -> overflow remains 1.
REQ-040 clrn pulse during REPEAT with key held -> all outputs at reset values; after release one immediate push, then repeat restarts at +8.
